// File: rtl/control_pipeline_pkg.sv
// Shared encodings and the E-stage control bundle for the pipeline control path.
package control_pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  // result_src encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // EX operand forward selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Decoded control carried into EX; all-zero is a bubble
  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  alu_src_a;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_e_t;

endpackage

// File: rtl/control_pipeline_if.sv
// Decoder bundle in, staged control / hazard controls / counters out.
interface control_pipeline_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  reg_write_d, mem_write_d, mem_read_d, jump_d, branch_d, alu_src_d, ALUSrcA_d;
  logic [1:0]            result_src_d, alu_op_d;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic                  pc_src_e, mem_busy, cnt_clr;

  logic                  reg_write_e, mem_write_e, mem_read_e, jump_e, branch_e, alu_src_e, ALUSrcA_e;
  logic [1:0]            result_src_e, alu_op_e;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic                  reg_write_m, mem_write_m, mem_read_m;
  logic [1:0]            result_src_m;
  logic [REG_ADDR_W-1:0] rd_m;
  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  stall_f, stall_d, flush_d, flush_e;
  logic [1:0]            forward_a_e, forward_b_e;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport slave (
    input  reg_write_d, result_src_d, mem_write_d, mem_read_d, jump_d, branch_d, alu_src_d,
           alu_op_d, ALUSrcA_d, rs1_d, rs2_d, rd_d, pc_src_e, mem_busy, cnt_clr,
    output reg_write_e, result_src_e, mem_write_e, mem_read_e, jump_e, branch_e, alu_src_e,
           alu_op_e, ALUSrcA_e, rs1_e, rs2_e, rd_e, reg_write_m, mem_write_m, mem_read_m,
           result_src_m, rd_m, reg_write_w, result_src_w, rd_w, stall_f, stall_d, flush_d,
           flush_e, forward_a_e, forward_b_e, stall_cnt, flush_cnt
  );

  modport master (
    output reg_write_d, result_src_d, mem_write_d, mem_read_d, jump_d, branch_d, alu_src_d,
           alu_op_d, ALUSrcA_d, rs1_d, rs2_d, rd_d, pc_src_e, mem_busy, cnt_clr,
    input  reg_write_e, result_src_e, mem_write_e, mem_read_e, jump_e, branch_e, alu_src_e,
           alu_op_e, ALUSrcA_e, rs1_e, rs2_e, rd_e, reg_write_m, mem_write_m, mem_read_m,
           result_src_m, rd_m, reg_write_w, result_src_w, rd_w, stall_f, stall_d, flush_d,
           flush_e, forward_a_e, forward_b_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/control_pipeline_hazard_forward_unit.sv
// Load-use detection, stall/flush priority and EX forwarding selects (pure combinational).
module control_pipeline_hazard_forward_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  mem_read_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  pc_src_e,
  input  logic                  mem_busy,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e
);
  import control_pipeline_pkg::*;

  logic lw_stall;

  // M result is younger than W, so it wins when both match; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic rw_m, input logic [REG_ADDR_W-1:0] dst_m,
                                         input logic rw_w, input logic [REG_ADDR_W-1:0] dst_w);
    if (rw_m && dst_m != '0 && dst_m == rs) return FWD_M;
    if (rw_w && dst_w != '0 && dst_w == rs) return FWD_W;
    return FWD_RF;
  endfunction

  assign lw_stall = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority: memory freeze, then redirect (squashes D so load-use is moot), then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
  assign forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers plus hazard controls and stall/flush counters.
module control_pipeline #(
  parameter int REG_ADDR_W = control_pipeline_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  control_pipeline_if.slave bus
);
  import control_pipeline_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  ctrl_e_t               d_bundle, e_q;
  logic                  reg_write_m_q, mem_write_m_q, mem_read_m_q, reg_write_w_q;
  logic [1:0]            result_src_m_q, result_src_w_q;
  logic [REG_ADDR_W-1:0] rd_m_q, rd_w_q;
  logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;
  logic                  stall_d, flush_e;

  assign d_bundle = '{reg_write: bus.reg_write_d, result_src: bus.result_src_d,
                      mem_write: bus.mem_write_d, mem_read: bus.mem_read_d,
                      jump: bus.jump_d, branch: bus.branch_d, alu_src: bus.alu_src_d,
                      alu_op: bus.alu_op_d, alu_src_a: bus.ALUSrcA_d,
                      rs1: bus.rs1_d, rs2: bus.rs2_d, rd: bus.rd_d};

  control_pipeline_hazard_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_forward_unit (
    .mem_read_e  (e_q.mem_read),
    .rd_e        (e_q.rd),
    .rs1_d       (bus.rs1_d),
    .rs2_d       (bus.rs2_d),
    .pc_src_e    (bus.pc_src_e),
    .mem_busy    (bus.mem_busy),
    .rs1_e       (e_q.rs1),
    .rs2_e       (e_q.rs2),
    .reg_write_m (reg_write_m_q),
    .rd_m        (rd_m_q),
    .reg_write_w (reg_write_w_q),
    .rd_w        (rd_w_q),
    .stall_f     (bus.stall_f),
    .stall_d     (stall_d),
    .flush_d     (bus.flush_d),
    .flush_e     (flush_e),
    .forward_a_e (bus.forward_a_e),
    .forward_b_e (bus.forward_b_e)
  );

  // Control registers: freeze on mem_busy, bubble into E on flush_e, otherwise advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q            <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_read_m_q   <= 1'b0;
      result_src_m_q <= RES_ALU;
      rd_m_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= RES_ALU;
      rd_w_q         <= '0;
    end else if (!bus.mem_busy) begin
      e_q            <= flush_e ? '0 : d_bundle;
      reg_write_m_q  <= e_q.reg_write;
      mem_write_m_q  <= e_q.mem_write;
      mem_read_m_q   <= e_q.mem_read;
      result_src_m_q <= e_q.result_src;
      rd_m_q         <= e_q.rd;
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
      rd_w_q         <= rd_m_q;
    end
  end

  // Saturating perf counters; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (bus.flush_d && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign bus.stall_d      = stall_d;
  assign bus.flush_e      = flush_e;
  assign bus.reg_write_e  = e_q.reg_write;
  assign bus.result_src_e = e_q.result_src;
  assign bus.mem_write_e  = e_q.mem_write;
  assign bus.mem_read_e   = e_q.mem_read;
  assign bus.jump_e       = e_q.jump;
  assign bus.branch_e     = e_q.branch;
  assign bus.alu_src_e    = e_q.alu_src;
  assign bus.alu_op_e     = e_q.alu_op;
  assign bus.ALUSrcA_e    = e_q.alu_src_a;
  assign bus.rs1_e        = e_q.rs1;
  assign bus.rs2_e        = e_q.rs2;
  assign bus.rd_e         = e_q.rd;
  assign bus.reg_write_m  = reg_write_m_q;
  assign bus.mem_write_m  = mem_write_m_q;
  assign bus.mem_read_m   = mem_read_m_q;
  assign bus.result_src_m = result_src_m_q;
  assign bus.rd_m         = rd_m_q;
  assign bus.reg_write_w  = reg_write_w_q;
  assign bus.result_src_w = result_src_w_q;
  assign bus.rd_w         = rd_w_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed vector table plus hand sequences for the multi-cycle corners.
module tb_control_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  control_pipeline_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

  control_pipeline #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rw, mr;
    logic [4:0] rs1, rs2, rd;
    logic       pc, busy;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
    logic [4:0] rde, rdm, rdw;
    logic [15:0] sc, fc;
    logic       mre;
    logic [1:0] rsw;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic rw, mr, input int rs1, rs2, rd,
                              input logic pc, busy, st, fd, fe,
                              input int fa, fb, rde, rdm, rdw, sc, fc,
                              input logic mre, input int rsw);
    vec_t v;
    v.rw = rw; v.mr = mr; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.pc = pc; v.busy = busy; v.st = st; v.fd = fd; v.fe = fe;
    v.fa = 2'(fa); v.fb = 2'(fb); v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.sc = 16'(sc); v.fc = 16'(fc); v.mre = mre; v.rsw = 2'(rsw);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_d(input logic rw, mr, input logic [4:0] rs1, rs2, rd);
    bus.reg_write_d  = rw;
    bus.mem_read_d   = mr;
    bus.result_src_d = mr ? 2'b01 : 2'b00;
    bus.mem_write_d  = 1'b0;
    bus.jump_d       = 1'b0;
    bus.branch_d     = 1'b0;
    bus.alu_src_d    = 1'b0;
    bus.alu_op_d     = 2'b00;
    bus.ALUSrcA_d    = 1'b0;
    bus.rs1_d        = rs1;
    bus.rs2_d        = rs2;
    bus.rd_d         = rd;
  endtask

  initial begin
    drive_d(0, 0, 0, 0, 0);
    bus.pc_src_e = 0; bus.mem_busy = 0; bus.cnt_clr = 0;

    //            rw mr rs1 rs2 rd pc bsy st fd fe fa fb rde rdm rdw sc fc mre rsw
    vt[0]  = mk(1, 1, 0, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // lw x5
    vt[1]  = mk(1, 0, 5, 7, 6,  0, 0, 1, 0, 1, 0, 0, 5, 0, 0, 0, 0, 1, 0); // add x6,x5,x7 load-use
    vt[2]  = mk(1, 0, 5, 7, 6,  0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 6, 0, 5, 1, 0, 0, 1); // add in E, lw in W
    vt[4]  = mk(1, 0, 1, 2, 3,  0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0); // add x3
    vt[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, 0, 6, 1, 0, 0, 0); // nop
    vt[6]  = mk(1, 0, 3, 3, 4,  0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0); // sub x4,x3,x3
    vt[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 4, 0, 3, 1, 0, 0, 0); // W forward
    vt[8]  = mk(1, 0, 1, 2, 3,  0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0); // add x3
    vt[9]  = mk(1, 0, 3, 3, 4,  0, 0, 0, 0, 0, 0, 0, 3, 0, 4, 1, 0, 0, 0); // sub x4,x3,x3
    vt[10] = mk(1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2, 2, 4, 3, 0, 1, 0, 0, 0); // M forward; D writes x0
    vt[11] = mk(1, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    vt[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 7, 0, 4, 1, 0, 0, 0); // x0 in M never forwards
    vt[13] = mk(1, 0, 1, 2, 3,  0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0);
    vt[14] = mk(1, 0, 1, 2, 3,  0, 0, 0, 0, 0, 0, 0, 3, 0, 7, 1, 0, 0, 0);
    vt[15] = mk(1, 0, 3, 3, 4,  0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 1, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 2, 4, 3, 3, 1, 0, 0, 0); // M beats W
    vt[17] = mk(1, 1, 0, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0, 0); // lw x5
    vt[18] = mk(1, 0, 5, 5, 6,  1, 0, 0, 1, 1, 0, 0, 5, 0, 4, 1, 0, 1, 0); // redirect beats load-use
    vt[19] = mk(1, 0, 1, 2, 9,  0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0);
    vt[20] = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 9, 0, 5, 1, 1, 0, 1); // busy beats redirect
    vt[21] = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 9, 0, 5, 2, 1, 0, 1);
    vt[22] = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 9, 0, 5, 3, 1, 0, 1);
    vt[23] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 9, 0, 5, 4, 1, 0, 1); // release: redirect now
    vt[24] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 4, 2, 0, 0);

    // Reset state, then idle pipeline stays empty
    #12;
    chk("reset_rd_e", bus.rd_e, 0);
    chk("reset_ctrl_e", {bus.reg_write_e, bus.mem_read_e, bus.mem_write_e, bus.jump_e}, 0);
    chk("reset_cnt", {bus.stall_cnt, bus.flush_cnt}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_w", {bus.reg_write_w, bus.result_src_w, bus.rd_w}, 0);
    chk("idle_hz", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.forward_a_e, bus.forward_b_e}, 0);

    // Vector table: outputs sampled mid-cycle before the edge
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive_d(vt[i].rw, vt[i].mr, vt[i].rs1, vt[i].rs2, vt[i].rd);
      bus.pc_src_e = vt[i].pc;
      bus.mem_busy = vt[i].busy;
      #2;
      chk($sformatf("v%0d_stall_f", i), bus.stall_f, vt[i].st);
      chk($sformatf("v%0d_stall_d", i), bus.stall_d, vt[i].st);
      chk($sformatf("v%0d_flush_d", i), bus.flush_d, vt[i].fd);
      chk($sformatf("v%0d_flush_e", i), bus.flush_e, vt[i].fe);
      chk($sformatf("v%0d_fwd_a", i), bus.forward_a_e, vt[i].fa);
      chk($sformatf("v%0d_fwd_b", i), bus.forward_b_e, vt[i].fb);
      chk($sformatf("v%0d_rd_e", i), bus.rd_e, vt[i].rde);
      chk($sformatf("v%0d_rd_m", i), bus.rd_m, vt[i].rdm);
      chk($sformatf("v%0d_rd_w", i), bus.rd_w, vt[i].rdw);
      chk($sformatf("v%0d_stall_cnt", i), bus.stall_cnt, vt[i].sc);
      chk($sformatf("v%0d_flush_cnt", i), bus.flush_cnt, vt[i].fc);
      chk($sformatf("v%0d_mem_read_e", i), bus.mem_read_e, vt[i].mre);
      chk($sformatf("v%0d_result_src_w", i), bus.result_src_w, vt[i].rsw);
    end

    // Counter clear, then saturation under a long memory freeze
    @(negedge clk);
    drive_d(0, 0, 0, 0, 0); bus.pc_src_e = 0; bus.mem_busy = 0; bus.cnt_clr = 1;
    @(posedge clk); #1;
    chk("clr_cnt", {bus.stall_cnt, bus.flush_cnt}, 0);
    @(negedge clk); bus.cnt_clr = 0; bus.mem_busy = 1;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    chk("sat_fffe", bus.stall_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_ffff", bus.stall_cnt, 16'hFFFF);
    @(negedge clk); bus.cnt_clr = 1;
    #1;
    chk("clr_with_stall_d", bus.stall_d, 1);
    @(posedge clk); #1;
    chk("clr_beats_inc", bus.stall_cnt, 0);
    @(negedge clk); bus.cnt_clr = 0; bus.mem_busy = 0;

    // Every E-stage field propagates; M and W keep only their subsets
    bus.reg_write_d = 1; bus.result_src_d = 2'b10; bus.mem_write_d = 1; bus.mem_read_d = 0;
    bus.jump_d = 1; bus.branch_d = 1; bus.alu_src_d = 1; bus.alu_op_d = 2'b11; bus.ALUSrcA_d = 1;
    bus.rs1_d = 5'd9; bus.rs2_d = 5'd10; bus.rd_d = 5'd8;
    @(posedge clk); #1;
    chk("full_e", {bus.reg_write_e, bus.result_src_e, bus.mem_write_e, bus.mem_read_e, bus.jump_e,
                   bus.branch_e, bus.alu_src_e, bus.alu_op_e, bus.ALUSrcA_e, bus.rs1_e, bus.rs2_e, bus.rd_e},
        {1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 5'd9, 5'd10, 5'd8});
    @(negedge clk); drive_d(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("full_m", {bus.reg_write_m, bus.result_src_m, bus.mem_write_m, bus.mem_read_m, bus.rd_m},
        {1'b1, 2'b10, 1'b1, 1'b0, 5'd8});
    @(posedge clk); #1;
    chk("full_w", {bus.reg_write_w, bus.result_src_w, bus.rd_w}, {1'b1, 2'b10, 5'd8});

    // Reset during a load-use stall drops the in-flight load at once
    @(negedge clk); drive_d(1, 1, 0, 0, 5);
    @(negedge clk); drive_d(1, 0, 5, 0, 6);
    #1;
    chk("pre_rst_stall", bus.stall_d, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {bus.stall_d, bus.flush_e, bus.mem_read_e, bus.rd_e}, 0);
    chk("rst_mid_cnt", bus.stall_cnt, 0);
    @(negedge clk); drive_d(0, 0, 0, 0, 0); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", {bus.rd_e, bus.rd_m, bus.rd_w, bus.reg_write_m, bus.reg_write_w}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
